// File: rtl/round_seq_pkg.sv
// Shared types for the round sequencer: FSM state encoding and
// banner image numbers.
package round_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REGEN,
        S_COUNTDOWN,
        S_RUN,
        S_PAUSE,
        S_CLEARED,
        S_OVER
    } state_e;

    localparam int IMG_TITLE   = 0;
    localparam int IMG_PAUSE   = 1;
    localparam int IMG_CLEARED = 2;
    localparam int IMG_OVER    = 3;

endpackage

// File: rtl/button_edge.sv
// Rising-edge detector for a level button. The history flop clears on
// reset, so a button held through reset release reads as a fresh press.
module button_edge (
    input  logic clk,
    input  logic arst_n,
    input  logic i_btn,
    output logic o_rise
);

    logic prev_q;
    logic prev_d;

    assign prev_d = i_btn;
    assign o_rise = i_btn & ~prev_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/round_sequencer.sv
// Match/round sequencer: title, regeneration, countdown, run, pause and
// game-over banners. Define ROUND_SEQ_LIVES_EN to enable the lives counter.
module round_sequencer
    import round_seq_pkg::*;
#(
    parameter int TICK_CYCLES   = 25_000_000,
    parameter int COUNTDOWN_SEC = 3,
    parameter int LIVES         = 3,
    parameter int RATING_WIDTH  = 8,
    parameter int NUM_IMAGES    = 4
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic                          i_start,
    input  logic                          i_pause,
    input  logic                          i_win,
    input  logic                          i_lose,
    input  logic                          i_ready,
    output logic                          o_regenerate_level,
    output logic                          o_game_running,
    output logic [$clog2(NUM_IMAGES)-1:0] o_image_number,
    output logic [RATING_WIDTH-1:0]       o_rating,
    output logic [2:0]                    o_lives,
    output logic [3:0]                    o_countdown
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int IW = $clog2(NUM_IMAGES);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    if (COUNTDOWN_SEC < 1 || COUNTDOWN_SEC > 15) begin : g_bad_countdown
        $error("COUNTDOWN_SEC must be 1..15");
    end
    if (LIVES < 1 || LIVES > 7) begin : g_bad_lives
        $error("LIVES must be 1..7");
    end

    state_e                  state_q, state_d;
    logic [TW-1:0]           tick_q, tick_d;
    logic [3:0]              cd_q, cd_d;
    logic [RATING_WIDTH-1:0] rating_q, rating_d;
    logic                    regen_q, regen_d;
    logic                    start_rise;
    logic                    pause_rise;
`ifdef ROUND_SEQ_LIVES_EN
    logic [2:0]              lives_q, lives_d;
`endif

    button_edge u_start_edge (
        .clk   (clk),
        .arst_n(arst_n),
        .i_btn (i_start),
        .o_rise(start_rise)
    );

    button_edge u_pause_edge (
        .clk   (clk),
        .arst_n(arst_n),
        .i_btn (i_pause),
        .o_rise(pause_rise)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= S_IDLE;
            tick_q   <= '0;
            cd_q     <= '0;
            rating_q <= '0;
            regen_q  <= 1'b0;
`ifdef ROUND_SEQ_LIVES_EN
            lives_q  <= 3'(LIVES);
`endif
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            cd_q     <= cd_d;
            rating_q <= rating_d;
            regen_q  <= regen_d;
`ifdef ROUND_SEQ_LIVES_EN
            lives_q  <= lives_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        cd_d     = cd_q;
        rating_d = rating_q;
`ifdef ROUND_SEQ_LIVES_EN
        lives_d  = lives_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start_rise) state_d = S_REGEN;
            end
            // regen_q marks the request cycle; ready is not trusted there
            S_REGEN: begin
                if (i_ready && !regen_q) begin
                    state_d = S_COUNTDOWN;
                    cd_d    = 4'(COUNTDOWN_SEC);
                    tick_d  = '0;
                end
            end
            S_COUNTDOWN: begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    cd_d   = cd_q - 4'd1;
                    if (cd_q == 4'd1) state_d = S_RUN;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            S_RUN: begin
                if (i_lose) begin
`ifdef ROUND_SEQ_LIVES_EN
                    lives_d = lives_q - 3'd1;
                    state_d = (lives_q == 3'd1) ? S_OVER : S_REGEN;
`else
                    state_d = S_OVER;
`endif
                end else if (i_win) begin
                    if (rating_q != '1) rating_d = rating_q + 1'b1;
                    state_d = S_CLEARED;
                end else if (pause_rise) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (pause_rise || start_rise) state_d = S_RUN;
            end
            S_CLEARED: begin
                if (start_rise) state_d = S_REGEN;
            end
            S_OVER: begin
                if (start_rise) begin
                    rating_d = '0;
`ifdef ROUND_SEQ_LIVES_EN
                    lives_d  = 3'(LIVES);
`endif
                    state_d  = S_REGEN;
                end
            end
            default: state_d = S_IDLE;
        endcase
        regen_d = (state_d == S_REGEN) && (state_q != S_REGEN);
    end

    always_comb begin
        o_game_running = 1'b0;
        o_image_number = IW'(IMG_TITLE);
        o_countdown    = 4'd0;
        unique case (state_q)
            S_RUN:       o_game_running = 1'b1;
            S_PAUSE:     o_image_number = IW'(IMG_PAUSE);
            S_CLEARED:   o_image_number = IW'(IMG_CLEARED);
            S_OVER:      o_image_number = IW'(IMG_OVER);
            S_COUNTDOWN: o_countdown    = cd_q;
            default:     ;
        endcase
    end

    assign o_regenerate_level = regen_q;
    assign o_rating           = rating_q;
`ifdef ROUND_SEQ_LIVES_EN
    assign o_lives            = lives_q;
`else
    assign o_lives            = 3'd0;
`endif

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer: vector table for the first round,
// then hand-written sequences for pause, saturation, lives and reset.
module tb_round_sequencer;

`ifdef ROUND_SEQ_LIVES_EN
    localparam int LV = 3;
`else
    localparam int LV = 0;
`endif

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       i_start = 1'b0;
    logic       i_pause = 1'b0;
    logic       i_win = 1'b0;
    logic       i_lose = 1'b0;
    logic       i_ready = 1'b0;
    logic       o_regenerate_level;
    logic       o_game_running;
    logic [1:0] o_image_number;
    logic [7:0] o_rating;
    logic [2:0] o_lives;
    logic [3:0] o_countdown;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int s, p, w, l, r, rep;
        int eg, er, img, rat, lv, cd;
    } vec_t;

    vec_t tbl[$];

    round_sequencer #(
        .TICK_CYCLES  (4),
        .COUNTDOWN_SEC(3),
        .LIVES        (3),
        .RATING_WIDTH (8),
        .NUM_IMAGES   (4)
    ) dut (
        .clk               (clk),
        .arst_n            (arst_n),
        .i_start           (i_start),
        .i_pause           (i_pause),
        .i_win             (i_win),
        .i_lose            (i_lose),
        .i_ready           (i_ready),
        .o_regenerate_level(o_regenerate_level),
        .o_game_running    (o_game_running),
        .o_image_number    (o_image_number),
        .o_rating          (o_rating),
        .o_lives           (o_lives),
        .o_countdown       (o_countdown)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(int s, int p, int w, int l, int r, int rep,
                                int eg, int er, int img, int rat, int lv, int cd);
        vec_t v;
        v.s = s; v.p = p; v.w = w; v.l = l; v.r = r; v.rep = rep;
        v.eg = eg; v.er = er; v.img = img; v.rat = rat; v.lv = lv; v.cd = cd;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] got, int exp);
        checks++;
        if (got !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", nm, got, exp);
        end
    endtask

    task automatic chk_all(string nm, int eg, int er, int img, int rat, int lv, int cd);
        chk({nm, ".regen"}, 32'(o_regenerate_level), eg);
        chk({nm, ".running"}, 32'(o_game_running), er);
        chk({nm, ".image"}, 32'(o_image_number), img);
        chk({nm, ".rating"}, 32'(o_rating), rat);
        chk({nm, ".lives"}, 32'(o_lives), lv);
        chk({nm, ".countdown"}, 32'(o_countdown), cd);
    endtask

    task automatic cyc(int s, int p, int w, int l, int r);
        i_start = (s != 0);
        i_pause = (p != 0);
        i_win   = (w != 0);
        i_lose  = (l != 0);
        i_ready = (r != 0);
        @(posedge clk);
        #1;
    endtask

    task automatic regen_to_run();
        cyc(0, 0, 0, 0, 0);
        chk("regen_once", 32'(o_regenerate_level), 0);
        cyc(0, 0, 0, 0, 1);
        chk("cd_load", 32'(o_countdown), 3);
        repeat (12) cyc(0, 0, 0, 0, 0);
        chk("to_run", 32'(o_game_running), 1);
    endtask

    task automatic play_to_run();
        cyc(1, 0, 0, 0, 0);
        chk("regen_pulse", 32'(o_regenerate_level), 1);
        regen_to_run();
    endtask

    initial begin
        // first round: start, ignored early ready, countdown 3-2-1, run
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, LV, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, LV, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, LV, 3));
        tbl.push_back(mk(0, 0, 1, 1, 0, 3, 0, 0, 0, 0, LV, 3));
        tbl.push_back(mk(0, 1, 0, 0, 0, 4, 0, 0, 0, 0, LV, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4, 0, 0, 0, 0, LV, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, LV, 0));

        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0, LV, 0);
        arst_n = 1'b1;
        cyc(0, 0, 0, 0, 1);
        chk_all("idle", 0, 0, 0, 0, LV, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            for (int k = 0; k < tbl[i].rep; k++) begin
                cyc(tbl[i].s, tbl[i].p, tbl[i].w, tbl[i].l, tbl[i].r);
                chk_all($sformatf("vec%0d_%0d", i, k), tbl[i].eg, tbl[i].er,
                        tbl[i].img, tbl[i].rat, tbl[i].lv, tbl[i].cd);
            end
        end

        cyc(0, 1, 0, 0, 0);
        chk_all("pause", 0, 0, 1, 0, LV, 0);
        cyc(0, 1, 0, 0, 0);
        chk_all("pause_held", 0, 0, 1, 0, LV, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 0, 0, 0);
            chk_all($sformatf("start_held%0d", i), 0, 1, 0, 0, LV, 0);
        end
        cyc(0, 0, 0, 0, 0);

        cyc(0, 0, 1, 0, 0);
        chk_all("win", 0, 0, 2, 1, LV, 0);
        cyc(0, 0, 1, 1, 0);
        chk_all("cleared_ignore", 0, 0, 2, 1, LV, 0);

        for (int k = 2; k <= 255; k++) begin
            play_to_run();
            cyc(0, 0, 1, 0, 0);
            chk("rating_inc", 32'(o_rating), k);
        end
        play_to_run();
        cyc(0, 0, 1, 0, 0);
        chk_all("rating_sat", 0, 0, 2, 255, LV, 0);

        play_to_run();
        cyc(0, 0, 1, 1, 0);
`ifdef ROUND_SEQ_LIVES_EN
        chk_all("win_lose", 1, 0, 0, 255, 2, 0);
        regen_to_run();
        cyc(0, 0, 0, 1, 0);
        chk_all("lose2", 1, 0, 0, 255, 1, 0);
        regen_to_run();
        cyc(0, 0, 0, 1, 0);
        chk_all("lose3", 0, 0, 3, 255, 0, 0);
`else
        chk_all("win_lose", 0, 0, 3, 255, 0, 0);
`endif
        cyc(0, 0, 1, 1, 0);
        chk_all("over_ignore", 0, 0, 3, 255, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk_all("restart", 1, 0, 0, 0, LV, 0);

        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        repeat (4) cyc(0, 0, 0, 0, 0);
        chk_all("cd2", 0, 0, 0, 0, LV, 2);
        arst_n = 1'b0;
        i_ready = 1'b1;
        #1;
        chk_all("rst_async", 0, 0, 0, 0, LV, 0);
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 1);
            chk_all($sformatf("post_rst%0d", i), 0, 0, 0, 0, LV, 0);
        end

        arst_n = 1'b0;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        cyc(1, 0, 0, 0, 0);
        chk_all("held_thru_rst", 1, 0, 0, 0, LV, 0);
        cyc(1, 0, 0, 0, 0);
        chk_all("held_no_repeat", 0, 0, 0, 0, LV, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/round_sequencer.md
ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 25_000_000, clock cycles per countdown second.
REQ-002 SHALL have parameter COUNTDOWN_SEC, default 3, countdown length in seconds (1..15).
REQ-003 SHALL have parameter LIVES, default 3, lives per match (1..7).
REQ-004 SHALL have parameter RATING_WIDTH, default 8, width of the levels-cleared counter.
REQ-005 SHALL have parameter NUM_IMAGES, default 4, number of banner images.
REQ-006 SHALL have port clk  in  1  system clock; one clock; all state on its rising edge.
REQ-007 SHALL have port arst_n  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port i_start  in  1  start/continue button, level.
REQ-009 SHALL have port i_pause  in  1  pause toggle button, level.
REQ-010 SHALL have port i_win  in  1  level cleared, from engine.
REQ-011 SHALL have port i_lose  in  1  player lost, OR of both engines.
REQ-012 SHALL have port i_ready  in  1  engine finished level regeneration.
REQ-013 SHALL have port o_regenerate_level  out  1  one-cycle regeneration request.
REQ-014 SHALL have port o_game_running  out  1  engines advance; banner hidden.
REQ-015 SHALL have port o_image_number  out  $clog2(NUM_IMAGES)  banner select.
REQ-016 SHALL have port o_rating  out  RATING_WIDTH  levels cleared this match.
REQ-017 SHALL have port o_lives  out  3  remaining lives.
REQ-018 SHALL have port o_countdown  out  4  remaining countdown seconds.

Function
REQ-019 SHALL detect rising edges of i_start and i_pause (input AND NOT previous-cycle value); only edges act, held buttons do not repeat.
REQ-020 SHALL implement states IDLE, REGEN, COUNTDOWN, RUN, PAUSE, CLEARED, OVER.
REQ-021 IDLE: start edge -> REGEN.
REQ-022 o_regenerate_level SHALL be registered, high exactly the first cycle after every entry to REGEN; i_ready SHALL be ignored in that cycle.
REQ-023 REGEN: i_ready=1 (from second cycle) -> COUNTDOWN, load countdown=COUNTDOWN_SEC, clear tick counter.
REQ-024 COUNTDOWN: tick counter counts 0..TICK_CYCLES-1 and wraps; each wrap decrements countdown; wrap with countdown=1 -> RUN, countdown=0.
REQ-025 RUN: priority i_lose > i_win > pause edge; start edge ignored.
REQ-026 RUN, i_lose: lives decrement; resulting lives=0 -> OVER, else -> REGEN.
REQ-027 RUN, i_win: rating increments, saturating at all-ones -> CLEARED.
REQ-028 RUN, pause edge -> PAUSE; PAUSE: pause or start edge -> RUN; tick counter and countdown frozen.
REQ-029 CLEARED: start edge -> REGEN.
REQ-030 OVER: start edge -> rating=0, lives=LIVES, -> REGEN.
REQ-031 i_win/i_lose SHALL be ignored outside RUN.
REQ-032 o_game_running=1 only in RUN.
REQ-033 o_image_number: 0 in IDLE/REGEN/COUNTDOWN, 1 in PAUSE, 2 in CLEARED, 3 in OVER, 0 in RUN.
REQ-034 o_countdown SHALL equal countdown register in COUNTDOWN, 0 elsewhere.
REQ-035 All outputs registered or decoded from registers only; no input-to-output combinational path.

Reset
REQ-036 arst_n low SHALL immediately force IDLE, rating=0, lives=LIVES, countdown=0, tick=0, edge history=0, o_regenerate_level=0, o_game_running=0, o_image_number=0.
REQ-037 A button held through reset release SHALL register as an edge on the first clock after release.
REQ-038 Reset mid-REGEN/COUNTDOWN SHALL abandon the round with no further regeneration pulse.

Configuration
REQ-039 Macro ROUND_SEQ_LIVES_EN defined: lives behaviour per REQ-026, o_lives as counter.
REQ-040 ROUND_SEQ_LIVES_EN undefined: lives logic absent, any RUN i_lose -> OVER, o_lives constant 0.

Structure
REQ-041 Package round_seq_pkg SHALL hold the state enum and image-number constants (IMG_TITLE=0, IMG_PAUSE=1, IMG_CLEARED=2, IMG_OVER=3).
REQ-042 One sub-module, button_edge (registered rising-edge detector), instantiated twice.

Verification (TICK_CYCLES=4, COUNTDOWN_SEC=3, LIVES=3, macro defined)
REQ-043 Reset, start edge, i_ready=1 two cycles later -> one regen pulse, countdown 3,2,1 each 4 cycles, then o_game_running=1, image 0.
REQ-044 RUN, i_win and i_lose same cycle -> lives 3->2, rating unchanged, new regen pulse.
REQ-045 Three losses -> OVER, image 3, lives 0; start edge -> rating 0, lives 3, regen pulse.
REQ-046 RUN, pause edge, start held 10 cycles -> PAUSE then RUN once only, image 1 while paused.
REQ-047 Rating forced 255, i_win -> rating stays 255, image 2.
REQ-048 arst_n low during COUNTDOWN countdown=2 -> IDLE, o_countdown=0, no regen pulse after release.
